// File: rtl/beamform_pkg.sv
// Shared constants and FSM type for the 4x4 mic-array delay-and-sum beamformer.
package beamform_pkg;

  localparam int unsigned PIXEL_ROW    = 45;
  localparam int unsigned PIXEL_COLUMN = 60;
  localparam int unsigned N_MIC        = 16;

  localparam int X_MIN = -30;
  localparam int Y_MIN = -22;
  localparam int X_MAX = X_MIN + int'(PIXEL_COLUMN) - 1;

  localparam int unsigned LAST_IDX  = PIXEL_ROW * PIXEL_COLUMN - 1;
  // Largest per-mic delay the delta generator can return.
  localparam int unsigned MAX_DELAY = 179;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned DELTA_W  = 8;
  localparam int unsigned COORD_W  = 6;
  localparam int unsigned SUM_W    = 20;
  localparam int unsigned SQ_W     = 39;
  localparam int unsigned POWER_W  = 44;
  localparam int unsigned IDX_W    = 12;

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, OUT} scan_state_e;

endpackage

// File: rtl/delay_sum_scanner_if.sv
// Sample-in, delta lookup and pixel-out signals of the delay-and-sum scanner.
interface delay_sum_scanner_if;
  import beamform_pkg::*;

  logic                       i_sample_valid;
  logic                       o_sample_ready;
  logic signed [SAMPLE_W-1:0] i_sample [N_MIC];
  logic                       i_start;
  logic signed [COORD_W-1:0]  o_p_x;
  logic signed [COORD_W-1:0]  o_p_y;
  logic        [DELTA_W-1:0]  i_delta [N_MIC];
  logic                       o_pix_valid;
  logic                       i_pix_ready;
  logic        [POWER_W-1:0]  o_pix_power;
  logic        [IDX_W-1:0]    o_pix_idx;
  logic                       o_busy;
  logic                       o_frame_done;

  // Environment side: sample source, delta generator and heat-map sink.
  modport master (
    output i_sample_valid, i_sample, i_start, i_delta, i_pix_ready,
    input  o_sample_ready, o_p_x, o_p_y, o_pix_valid, o_pix_power, o_pix_idx, o_busy,
           o_frame_done
  );

  // Scanner side.
  modport slave (
    input  i_sample_valid, i_sample, i_start, i_delta, i_pix_ready,
    output o_sample_ready, o_p_x, o_p_y, o_pix_valid, o_pix_power, o_pix_idx, o_busy,
           o_frame_done
  );

endinterface

// File: rtl/mic_ring_buffer.sv
// Per-microphone sample store: one write port, one registered read port.
module mic_ring_buffer #(
  parameter int unsigned DEPTH = 256
) (
  input  logic                       i_clk,
  input  logic                       i_we,
  input  logic [$clog2(DEPTH)-1:0]   i_waddr,
  input  logic signed [15:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0]   i_raddr,
  output logic signed [15:0]         o_rdata
);

  logic signed [15:0] mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem[i_waddr] <= i_wdata;
    end
    o_rdata <= mem[i_raddr];
  end

endmodule

// File: rtl/delay_sum_scanner.sv
// Raster-scans the 60x45 image, delay-and-sums the 16 mic buffers per pixel and
// streams the accumulated beam power out one pixel at a time.
module delay_sum_scanner
  import beamform_pkg::*;
#(
  parameter int unsigned N_ACC = 32,
  parameter int unsigned DEPTH = 256
) (
  input logic              i_clk,
  input logic              i_rst,
  delay_sum_scanner_if.slave bus
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam int unsigned FW       = $clog2(DEPTH + 1);
  localparam int unsigned NW       = $clog2(N_ACC);
  localparam int unsigned FILL_MIN = N_ACC + MAX_DELAY;

  scan_state_e state_q, state_d;

  logic [AW-1:0]              wr_ptr_q, base_q;
  logic [FW-1:0]              fill_q;
  logic [DELTA_W-1:0]         dly_q [N_MIC];
  logic [NW-1:0]              n_q, n_d;
  logic signed [COORD_W-1:0]  p_x_q, p_x_d, p_y_q, p_y_d;
  logic [IDX_W-1:0]           idx_q, idx_d;

  logic busy, wr_en, start_ok, accept, last_pix;

  logic [AW-1:0]              rd_addr [N_MIC];
  logic signed [SAMPLE_W-1:0] rd_data [N_MIC];
  logic                       rd_v_q, sum_v_q;
  logic signed [SUM_W-1:0]    sum_d, sum_q;
  logic [SUM_W-1:0]           mag;
  logic [SQ_W-1:0]            sq;
  logic [POWER_W-1:0]         acc_q;

  assign busy     = (state_q != IDLE);
  assign wr_en    = bus.i_sample_valid && !busy;
  assign start_ok = (state_q == IDLE) && bus.i_start && (fill_q >= FW'(FILL_MIN));
  assign accept   = (state_q == OUT) && bus.i_pix_ready;
  assign last_pix = (idx_q == IDX_W'(LAST_IDX));

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    p_x_d   = p_x_q;
    p_y_d   = p_y_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (start_ok) state_d = LOAD;
      end
      LOAD: begin
        state_d = RUN;
        n_d     = '0;
      end
      RUN: begin
        if (n_q == NW'(N_ACC - 1)) begin
          state_d = DRAIN;
          n_d     = '0;
        end else begin
          n_d = n_q + NW'(1);
        end
      end
      // n_q is reused as the two-cycle drain counter.
      DRAIN: begin
        if (n_q == NW'(1)) state_d = OUT;
        else               n_d = n_q + NW'(1);
      end
      OUT: begin
        if (bus.i_pix_ready) begin
          if (last_pix) begin
            state_d = IDLE;
            p_x_d   = COORD_W'(X_MIN);
            p_y_d   = COORD_W'(Y_MIN);
            idx_d   = '0;
          end else begin
            state_d = LOAD;
            idx_d   = idx_q + IDX_W'(1);
            if (p_x_q == COORD_W'(X_MAX)) begin
              p_x_d = COORD_W'(X_MIN);
              p_y_d = p_y_q + COORD_W'(1);
            end else begin
              p_x_d = p_x_q + COORD_W'(1);
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      fill_q   <= '0;
      base_q   <= '0;
      n_q      <= '0;
      p_x_q    <= COORD_W'(X_MIN);
      p_y_q    <= COORD_W'(Y_MIN);
      idx_q    <= '0;
      rd_v_q   <= 1'b0;
      sum_v_q  <= 1'b0;
      sum_q    <= '0;
      acc_q    <= '0;
      for (int m = 0; m < N_MIC; m++) dly_q[m] <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      p_x_q   <= p_x_d;
      p_y_q   <= p_y_d;
      idx_q   <= idx_d;
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
        if (fill_q != FW'(DEPTH)) fill_q <= fill_q + FW'(1);
      end
      // Newest frame at start time anchors the whole scan.
      if (start_ok) base_q <= wr_ptr_q - AW'(1);
      if (state_q == LOAD) begin
        for (int m = 0; m < N_MIC; m++) dly_q[m] <= bus.i_delta[m];
      end
      rd_v_q  <= (state_q == RUN);
      sum_v_q <= rd_v_q;
      sum_q   <= sum_d;
      if (state_q == LOAD)  acc_q <= '0;
      else if (sum_v_q)     acc_q <= acc_q + POWER_W'(sq);
    end
  end

  always_comb begin
    sum_d = '0;
    for (int m = 0; m < N_MIC; m++) begin
      rd_addr[m] = base_q - AW'(n_q) - AW'(dly_q[m]);
      sum_d      = sum_d + {{(SUM_W - SAMPLE_W){rd_data[m][SAMPLE_W-1]}}, rd_data[m]};
    end
  end

  // Square via magnitude so the full 39-bit product is used.
  assign mag = sum_q[SUM_W-1] ? -sum_q : sum_q;
  assign sq  = SQ_W'(mag) * SQ_W'(mag);

  for (genvar m = 0; m < N_MIC; m++) begin : g_mic
    mic_ring_buffer #(
      .DEPTH (DEPTH)
    ) u_buf (
      .i_clk   (i_clk),
      .i_we    (wr_en),
      .i_waddr (wr_ptr_q),
      .i_wdata (bus.i_sample[m]),
      .i_raddr (rd_addr[m]),
      .o_rdata (rd_data[m])
    );
  end

  assign bus.o_sample_ready = !busy;
  assign bus.o_busy         = busy;
  assign bus.o_p_x          = p_x_q;
  assign bus.o_p_y          = p_y_q;
  assign bus.o_pix_valid    = (state_q == OUT);
  assign bus.o_pix_power    = acc_q;
  assign bus.o_pix_idx      = idx_q;
  assign bus.o_frame_done   = accept && last_pix;

endmodule

// File: tb/tb_delay_sum_scanner.sv
// Directed bench for delay_sum_scanner: thresholds, latency, backpressure, reset,
// a full DC frame and an impulse with forced deltas.
module tb_delay_sum_scanner;

  // Short window: frame length and all latencies scale with N_ACC.
  localparam int unsigned N_ACC      = 8;
  localparam int unsigned DEPTH      = 256;
  localparam int          FILL_MIN   = N_ACC + 179;
  localparam int          FIRST_LAT  = N_ACC + 3;
  localparam int          PIX_CYCLES = N_ACC + 4;
  localparam int          N_PIX      = 2700;
  localparam logic [43:0] DC_POWER   = 44'(2560000 * N_ACC);  // (16*100)^2 per sample
  localparam logic [71:0] RST_VEC    = {4'b1000, 44'd0, 12'd0, 6'b100010, 6'b101010};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic       delta_force = 1'b0;
  logic [7:0] delta_val   = 8'd0;
  int checks = 0;
  int errors = 0;

  delay_sum_scanner_if bus ();

  delay_sum_scanner #(
    .N_ACC (N_ACC),
    .DEPTH (DEPTH)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Delta generator stand-in: any delay 0..179 derived from the pixel and mic.
  always_comb begin
    for (int m = 0; m < 16; m++) begin
      if (delta_force) bus.i_delta[m] = delta_val;
      else bus.i_delta[m] = 8'(((int'(bus.o_p_x) + 30) + 2 * (int'(bus.o_p_y) + 22) + 7 * m)
                               % 180);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.i_sample_valid = 1'b0;
    bus.i_start = 1'b0;
    bus.i_pix_ready = 1'b0;
    for (int m = 0; m < 16; m++) bus.i_sample[m] = '0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic write_frames(input int n, input logic signed [15:0] v0,
                              input logic signed [15:0] vrest);
    bus.i_sample[0] = v0;
    for (int m = 1; m < 16; m++) bus.i_sample[m] = vrest;
    bus.i_sample_valid = 1'b1;
    repeat (n) tick();
    bus.i_sample_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus.o_sample_ready !== 1'b1) begin errors++;
      $display("FAIL reset_ready got=%b exp=1", bus.o_sample_ready); end
    checks++; if (bus.o_busy !== 1'b0) begin errors++;
      $display("FAIL reset_busy got=%b exp=0", bus.o_busy); end
    checks++; if (bus.o_pix_valid !== 1'b0) begin errors++;
      $display("FAIL reset_valid got=%b exp=0", bus.o_pix_valid); end
    checks++; if (bus.o_frame_done !== 1'b0) begin errors++;
      $display("FAIL reset_done got=%b exp=0", bus.o_frame_done); end
    checks++; if (bus.o_pix_power !== 44'd0) begin errors++;
      $display("FAIL reset_power got=%0d exp=0", bus.o_pix_power); end
    checks++; if (bus.o_pix_idx !== 12'd0) begin errors++;
      $display("FAIL reset_idx got=%0d exp=0", bus.o_pix_idx); end
    checks++; if (int'(bus.o_p_x) != -30) begin errors++;
      $display("FAIL reset_px got=%0d exp=-30", bus.o_p_x); end
    checks++; if (int'(bus.o_p_y) != -22) begin errors++;
      $display("FAIL reset_py got=%0d exp=-22", bus.o_p_y); end
  endtask

  task automatic test_start_threshold();
    int k;
    write_frames(FILL_MIN - 1, 16'sd100, 16'sd100);
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    repeat (3) tick();
    checks++; if (bus.o_busy !== 1'b0) begin errors++;
      $display("FAIL start_below_fill got busy=%b exp=0", bus.o_busy); end
    // The ignored request must not be remembered once fill reaches the threshold.
    write_frames(1, 16'sd100, 16'sd100);
    repeat (3) tick();
    checks++; if (bus.o_busy !== 1'b0) begin errors++;
      $display("FAIL start_not_latched got busy=%b exp=0", bus.o_busy); end
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    checks++; if (bus.o_busy !== 1'b1) begin errors++;
      $display("FAIL start_accept got busy=%b exp=1", bus.o_busy); end
    checks++; if (bus.o_sample_ready !== 1'b0) begin errors++;
      $display("FAIL busy_ready got=%b exp=0", bus.o_sample_ready); end
    k = 0;
    while (!bus.o_pix_valid && k < 200) begin tick(); k++; end
    checks++; if (k != FIRST_LAT) begin errors++;
      $display("FAIL first_valid_latency got=%0d exp=%0d", k, FIRST_LAT); end
  endtask

  // Continues the scan begun above: pixels 0..6, stalling on pixel 5.
  task automatic test_backpressure();
    int k;
    for (int p = 0; p <= 6; p++) begin
      if (p > 0) begin
        k = 0;
        while (!bus.o_pix_valid && k < 200) begin tick(); k++; end
        checks++; if (k != FIRST_LAT) begin errors++;
          $display("FAIL accept_to_valid p=%0d got=%0d exp=%0d", p, k, FIRST_LAT); end
      end
      checks++; if (bus.o_pix_idx !== 12'(p)) begin errors++;
        $display("FAIL bp_idx got=%0d exp=%0d", bus.o_pix_idx, p); end
      checks++; if (bus.o_pix_power !== DC_POWER) begin errors++;
        $display("FAIL bp_power p=%0d got=%0d exp=%0d", p, bus.o_pix_power, DC_POWER); end
      checks++; if (int'(bus.o_p_x) != p - 30 || int'(bus.o_p_y) != -22) begin errors++;
        $display("FAIL bp_coord got=(%0d,%0d) exp=(%0d,-22)", bus.o_p_x, bus.o_p_y, p - 30); end
      if (p == 5) begin
        repeat (10) begin
          tick();
          checks++;
          if ({bus.o_pix_valid, bus.o_pix_idx, bus.o_pix_power, bus.o_p_x, bus.o_p_y} !==
              {1'b1, 12'd5, DC_POWER, 6'b100111, 6'b101010}) begin
            errors++;
            $display("FAIL bp_hold got v=%b idx=%0d pw=%0d x=%0d y=%0d exp v=1 idx=5 pw=%0d",
                     bus.o_pix_valid, bus.o_pix_idx, bus.o_pix_power, bus.o_p_x, bus.o_p_y,
                     DC_POWER);
          end
        end
      end
      if (p < 6) begin
        bus.i_pix_ready = 1'b1;
        tick();
        bus.i_pix_ready = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid_run();
    bus.i_pix_ready = 1'b1;
    tick();
    bus.i_pix_ready = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.o_sample_ready, bus.o_busy, bus.o_pix_valid, bus.o_frame_done, bus.o_pix_power,
         bus.o_pix_idx, bus.o_p_x, bus.o_p_y} !== RST_VEC) begin
      errors++;
      $display("FAIL midrun_reset got=%h exp=%h", {bus.o_sample_ready, bus.o_busy,
               bus.o_pix_valid, bus.o_frame_done, bus.o_pix_power, bus.o_pix_idx, bus.o_p_x,
               bus.o_p_y}, RST_VEC);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if ({bus.o_sample_ready, bus.o_busy, bus.o_pix_valid, bus.o_frame_done, bus.o_pix_power,
         bus.o_pix_idx, bus.o_p_x, bus.o_p_y} !== RST_VEC) begin
      errors++;
      $display("FAIL after_reset got=%h exp=%h", {bus.o_sample_ready, bus.o_busy,
               bus.o_pix_valid, bus.o_frame_done, bus.o_pix_power, bus.o_pix_idx, bus.o_p_x,
               bus.o_p_y}, RST_VEC);
    end
    write_frames(100, 16'sd100, 16'sd100);
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    tick();
    checks++; if (bus.o_busy !== 1'b0) begin errors++;
      $display("FAIL start_after_100 got busy=%b exp=0", bus.o_busy); end
  endtask

  task automatic test_full_frame_dc();
    int beats, cyc, prev, dones;
    do_reset();
    write_frames(300, 16'sd100, 16'sd100);
    bus.i_pix_ready = 1'b1;
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    beats = 0; cyc = 0; prev = 0; dones = 0;
    while (beats < N_PIX && cyc < N_PIX * PIX_CYCLES + 100) begin
      if (bus.o_frame_done === 1'b1) dones++;
      if (bus.o_pix_valid === 1'b1) begin
        checks++; if (bus.o_pix_idx !== 12'(beats)) begin errors++;
          $display("FAIL frame_idx got=%0d exp=%0d", bus.o_pix_idx, beats); end
        checks++; if (bus.o_pix_power !== DC_POWER) begin errors++;
          $display("FAIL dc_power idx=%0d got=%0d exp=%0d", beats, bus.o_pix_power, DC_POWER);
        end
        checks++;
        if (int'(bus.o_p_x) != beats % 60 - 30 || int'(bus.o_p_y) != beats / 60 - 22) begin
          errors++;
          $display("FAIL frame_coord got=(%0d,%0d) exp=(%0d,%0d)", bus.o_p_x, bus.o_p_y,
                   beats % 60 - 30, beats / 60 - 22);
        end
        checks++; if (bus.o_frame_done !== (beats == N_PIX - 1)) begin errors++;
          $display("FAIL frame_done_beat idx=%0d got=%b", beats, bus.o_frame_done); end
        checks++;
        if (cyc - prev != ((beats == 0) ? FIRST_LAT : PIX_CYCLES)) begin errors++;
          $display("FAIL beat_gap idx=%0d got=%0d exp=%0d", beats, cyc - prev,
                   (beats == 0) ? FIRST_LAT : PIX_CYCLES);
        end
        prev = cyc;
        beats++;
      end
      tick();
      cyc++;
    end
    checks++; if (beats != N_PIX) begin errors++;
      $display("FAIL frame_beats got=%0d exp=%0d", beats, N_PIX); end
    checks++; if (dones != 1) begin errors++;
      $display("FAIL frame_done_count got=%0d exp=1", dones); end
    checks++; if (bus.o_sample_ready !== 1'b1 || bus.o_busy !== 1'b0) begin errors++;
      $display("FAIL frame_end got ready=%b busy=%b exp ready=1 busy=0", bus.o_sample_ready,
               bus.o_busy); end
    repeat (FIRST_LAT + 2) tick();
    checks++; if (bus.o_pix_valid !== 1'b0) begin errors++;
      $display("FAIL extra_beat got valid=%b exp=0", bus.o_pix_valid); end
    bus.i_pix_ready = 1'b0;
  endtask

  task automatic test_impulse();
    int k;
    do_reset();
    write_frames(200, 16'sd0, 16'sd0);
    write_frames(1, 16'sd1000, 16'sd0);
    delta_force = 1'b1;
    delta_val = 8'd0;
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    for (int p = 0; p < 3; p++) begin
      k = 0;
      while (!bus.o_pix_valid && k < 200) begin tick(); k++; end
      checks++; if (bus.o_pix_idx !== 12'(p)) begin errors++;
        $display("FAIL impulse_idx got=%0d exp=%0d", bus.o_pix_idx, p); end
      // Pixel 1 is loaded with delta 1 and misses the impulse.
      checks++;
      if (bus.o_pix_power !== ((p == 1) ? 44'd0 : 44'd1000000)) begin errors++;
        $display("FAIL impulse_power p=%0d got=%0d exp=%0d", p, bus.o_pix_power,
                 (p == 1) ? 0 : 1000000);
      end
      delta_val = (p == 0) ? 8'd1 : 8'd0;
      bus.i_pix_ready = 1'b1;
      tick();
      bus.i_pix_ready = 1'b0;
    end
    delta_force = 1'b0;
    do_reset();
  endtask

  initial begin
    test_reset();
    test_start_threshold();
    test_backpressure();
    test_reset_mid_run();
    test_full_frame_dc();
    test_impulse();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired before end of run");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/delay_sum_scanner.md
# delay_sum_scanner

Delay-and-sum power scanner for the 4×4 microphone array. It buffers incoming 16-channel sample frames in per-mic ring buffers. On start, it raster-scans every pixel of the 60×45 image: it drives pixel coordinates to the `Delta_generator`, reads each mic's buffer at the returned per-mic delays, and accumulates beamformed power over a window. It emits one power value per pixel over a valid/ready stream to the display/heat-map stage.

## Interface
- `N_ACC`, 32: samples accumulated per pixel
- `DEPTH`, 256: ring-buffer entries per mic (power of two, > `N_ACC` + 179)
- `i_clk`  in  1  sole clock
- `i_rst`  in  1  reset; asynchronous, active-high
- `i_sample_valid`  in  1  new 16-mic sample frame present
- `o_sample_ready`  out  1  frame accepted when high; low while scanning
- `i_sample[15:0]`  in  16×16 signed  one sample per mic
- `i_start`  in  1  start-frame request (level sampled each cycle)
- `o_p_x`  out  6 signed  pixel column to `Delta_generator`
- `o_p_y`  out  6 signed  pixel row to `Delta_generator`
- `i_delta[15:0]`  in  16×8  per-mic delay from `Delta_generator` (combinational return)
- `o_pix_valid`  out  1  pixel result valid
- `i_pix_ready`  in  1  downstream accepts result
- `o_pix_power`  out  44  unsigned accumulated power
- `o_pix_idx`  out  12  raster index 0..2699
- `o_busy`  out  1  high from start acceptance to frame end
- `o_frame_done`  out  1  one-cycle pulse on acceptance of pixel 2699

## Operation
- Write side:
  - A frame is written when `i_sample_valid && o_sample_ready`: all 16 buffers are written at `wr_ptr`, then `wr_ptr` increments mod `DEPTH`.
  - `fill` counts accepted frames and saturates at `DEPTH`.
  - `o_sample_ready = !o_busy`.
- `i_start` is accepted only in IDLE with `fill >= N_ACC+179` (211). Otherwise it is ignored, with no latching. On acceptance, `base = wr_ptr-1` (mod `DEPTH`) is latched.
- FSM states:
  - IDLE: on accepted start, go to LOAD.
  - LOAD, 1 cycle: `o_p_x`/`o_p_y` are already registered for the current pixel; capture `i_delta` into `dly_q[16]`; clear the accumulator and `n`.
  - RUN, `N_ACC` cycles: for sample `n` = 0..31, each mic m is read at address `(base - n - dly_q[m]) mod DEPTH`.
  - DRAIN, 2 cycles: flush the pipeline.
  - OUT: assert `o_pix_valid`. On `i_pix_ready`:
    - last pixel: go to IDLE, pulse `o_frame_done`, clear `o_busy`;
    - otherwise: advance the pixel and go to LOAD.
- Pipeline:
  - Stage 1: synchronous RAM read.
  - Stage 2: 20-bit signed sum of 16 samples.
  - Stage 3: square (39-bit unsigned) and add into the 44-bit accumulator.
- Scan order: `p_y` runs −22 to +22 in the outer loop and `p_x` runs −30 to +29 in the inner loop. `o_pix_idx = (p_y+22)*60 + (p_x+30)`.
- Width rules: no saturation is needed because the maximum is 2^38·32 < 2^44. Address arithmetic wraps mod `DEPTH`.

## Timing
- Reset values:
  - `o_sample_ready` = 1; `o_busy`, `o_pix_valid`, `o_frame_done` = 0.
  - `o_pix_power`, `o_pix_idx` = 0.
  - `o_p_x` = −30, `o_p_y` = −22.
  - `wr_ptr`, `fill` = 0; FSM = IDLE.
  - RAM contents are not cleared.
- `o_pix_valid` first rises 35 edges after the edge accepting `i_start`. With `i_pix_ready` held high, results follow every 36 cycles, so a full frame takes 97 200 cycles.
- While `o_pix_valid && !i_pix_ready`, `o_pix_power`, `o_pix_idx`, `o_p_x` and `o_p_y` hold stable.
- `o_p_x`/`o_p_y` update on the OUT→LOAD edge, so `i_delta` has one full cycle to settle before capture.
- `i_start` while busy is ignored. A simultaneous `i_sample_valid` during a busy scan is not written.
- Asserting `i_rst` mid-scan returns the block to reset values immediately. The next start requires 211 fresh frames.

## Structure
- Package `beamform_pkg`:
  - `PIXEL_ROW` = 45, `PIXEL_COLUMN` = 60, `N_MIC` = 16;
  - X_MIN = −30, Y_MIN = −22;
  - FSM enum {IDLE, LOAD, RUN, DRAIN, OUT};
  - power width 44.
- Sub-module `mic_ring_buffer`: one write port and one registered read port, 16 bits × `DEPTH`, instantiated 16× with generate.
- `Delta_generator` sits beside this block at the top level; it is not instantiated inside it.

## Test plan
- Reset mid-RUN: after release, all outputs are at their reset values, `o_sample_ready` = 1, and a start issued after only 100 frames is ignored.
- Write 210 frames, then pulse start: nothing happens. Write 1 more frame, then start: `o_busy` = 1 and the first `o_pix_valid` appears 35 edges later.
- DC input: write 300 frames (wrapping `wr_ptr`), all mics = 100, with the delta model connected. Every pixel gives `o_pix_power` = 81 920 000.
- Backpressure: hold `i_pix_ready` low for 10 cycles on pixel 5. Valid, power and `idx` = 5 stay stable, and the next valid arrives 36 cycles after acceptance.
- Full frame with ready high: exactly 2700 beats with `idx` 0..2699 in order, a single `o_frame_done` pulse with beat 2699, then `o_sample_ready` returns to 1.
- Impulse: mic 0 = 1000 at the newest sample and all other samples 0, with delta forced to 0. Pixel power = 1 000 000. With delta forced to 1, pixel power = 0.
